led_pattern_engine: RTL



---
 rtl/led_pkg.sv | 15 +
 rtl/key_edge_sync.sv | 41 ++++
 rtl/led_pattern_engine.sv | 128 ++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared display mode encoding for the LED pattern engine
//
// Purpose: mode_t enumeration shared by the engine and its bench.
//   MODE_BIN shows the counter as binary, MODE_BAR as a bar graph and
//   MODE_DOT as a single moving dot. Encoding 2'b11 has no name; logic
//   that decodes mode_t treats it as MODE_BIN.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_BIN = 2'd0,
    MODE_BAR = 2'd1,
    MODE_DOT = 2'd2
  } mode_t;

endpackage

// File: rtl/key_edge_sync.sv
// rtl/key_edge_sync.sv - pushbutton synchroniser and press detector
//
// Purpose: brings the asynchronous active-low pushbuttons into the CLOCK_50
//   domain and flags each press (released -> pressed) as a one-cycle pulse.
// Ports:
//   CLOCK_50   in   1  system clock
//   RESET_N    in   1  async reset, active low; all flops reset to released (1)
//   KEY_IN     in   N  raw button pins, active low
//   KEY_LVL    out  N  synchronised button levels (0 = pressed)
//   KEY_PRESS  out  N  one-cycle pulse on a synced 1->0 transition
module key_edge_sync #(
  parameter int N = 4
) (
  input  logic         CLOCK_50,
  input  logic         RESET_N,
  input  logic [N-1:0] KEY_IN,
  output logic [N-1:0] KEY_LVL,
  output logic [N-1:0] KEY_PRESS
);

  logic [N-1:0] sync1_q;
  logic [N-1:0] sync2_q;
  logic [N-1:0] prev_q;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
    end else begin
      sync1_q <= KEY_IN;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign KEY_LVL   = sync2_q;
  // Pin falls before edge 1; sync2 low after edge 2; the pulse is acted on at edge 3.
  assign KEY_PRESS = prev_q & ~sync2_q;

endmodule

// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - prescaled up/down counter rendered onto an LED bank
//
// Purpose: a prescaled tick steps a CNT_W-bit counter up (KEY[0] held) or
//   down; the counter is shown on LEDR as binary, bar graph or moving dot.
//   KEY[1] cycles the display mode, KEY[2] toggles pause/run, KEY[3] clears.
// Ports:
//   CLOCK_50  in   1      system clock
//   RESET_N   in   1      async reset, active low
//   KEY       in   4      pushbuttons, active low, asynchronous
//   LEDR      out  WIDTH  registered LED pattern
//   TICK      out  1      registered one-cycle pulse on each counter step
module led_pattern_engine
  import led_pkg::*;
#(
  parameter int WIDTH    = 18,
  parameter int CNT_W    = 8,
  parameter int PRESCALE = 500000
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic [3:0]       KEY,
  output logic [WIDTH-1:0] LEDR,
  output logic             TICK
);

  localparam int PS_W = $clog2(PRESCALE);
  localparam int N_W  = $clog2(WIDTH + 1);
  localparam int P_W  = CNT_W + $clog2(WIDTH + 1);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  logic [3:0]       key_lvl;
  logic [3:0]       key_press;
  logic [PS_W-1:0]  presc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  mode_t            mode_q;
  mode_t            mode_d;
  logic             tick;
  logic             clear;
  logic [P_W-1:0]   prod;
  logic [N_W-1:0]   n;
  logic [WIDTH-1:0] led_d;
  logic             unused_key_lvl;

  key_edge_sync #(.N(4)) u_keys (
    .CLOCK_50  (CLOCK_50),
    .RESET_N   (RESET_N),
    .KEY_IN    (KEY),
    .KEY_LVL   (key_lvl),
    .KEY_PRESS (key_press)
  );

  // Only the direction button is used as a level.
  assign unused_key_lvl = &{1'b0, key_lvl[3:1]};

  // The tick sees the run value from before any pause press in this cycle.
  assign tick  = run_q && (presc_q == PS_MAX);
  assign clear = key_press[3];

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      presc_q <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b1;
      TICK    <= 1'b0;
    end else begin
      if (clear) begin
        presc_q <= '0;
      end else if (run_q) begin
        presc_q <= (presc_q == PS_MAX) ? '0 : presc_q + PS_W'(1);
      end

      // Clear wins over a coincident tick, which is dropped entirely.
      if (clear) begin
        cnt_q <= '0;
      end else if (tick) begin
        cnt_q <= key_lvl[0] ? cnt_q - CNT_W'(1) : cnt_q + CNT_W'(1);
      end

      if (key_press[2]) begin
        run_q <= ~run_q;
      end

      TICK <= tick && !clear;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      mode_q <= MODE_BIN;
    end else begin
      mode_q <= mode_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (key_press[1]) begin
      case (mode_q)
        MODE_BIN: mode_d = MODE_BAR;
        MODE_BAR: mode_d = MODE_DOT;
        default:  mode_d = MODE_BIN;
      endcase
    end
  end

  // Scale the counter onto 0..WIDTH-1 LED positions.
  assign prod = P_W'(cnt_q) * P_W'(WIDTH);
  assign n    = N_W'(prod >> CNT_W);

  always_comb begin
    led_d = '0;
    case (mode_q)
      MODE_BAR: led_d = ~({WIDTH{1'b1}} << n);
      MODE_DOT: led_d = WIDTH'(1) << n;
      default:  led_d = WIDTH'(cnt_q);
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      LEDR <= '0;
    end else begin
      LEDR <= led_d;
    end
  end

endmodule
